// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared definitions for the register-file sequencer: command
//               opcodes, register-file FunSel codes, the sequencer state
//               type and the index-to-select decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    // Command opcodes (101-111 are illegal)
    localparam logic [2:0] OP_DEC    = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_CLR    = 3'b010;
    localparam logic [2:0] OP_LOAD32 = 3'b011;
    localparam logic [2:0] OP_READ   = 3'b100;

    // Register-file function selects
    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;
    localparam logic [2:0] FS_SHL8 = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR1  = 3'd1,
        ST_LB2  = 3'd2,
        ST_LB1  = 3'd3,
        ST_LB0  = 3'd4,
        ST_RD   = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    // One-hot target select: bits [3:0] are RegSel (R1-R4),
    // bits [7:4] are ScrSel (S1-S4).
    function automatic logic [7:0] idx_to_sel(input logic [2:0] idx);
        idx_to_sel = 8'b0000_0001 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rfseq_arbiter.sv
// ============================================================================
// Module      : rfseq_arbiter
// Description : Two-port grant logic for the register-file sequencer.
//               ARB_RR=1: round-robin on a tie (port not granted last wins).
//               ARB_RR=0: fixed priority, port 0 wins.
// Ports       : clk, rst (async, active-low), enable (sequencer idle),
//               req[1:0] (command valid), grant[1:0] (one-hot or zero,
//               only ever set on a requesting port while enabled)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfseq_arbiter #(
    parameter int ARB_RR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Port that wins the next tie; 0 after reset
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = ((ARB_RR != 0) && ptr) ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // A non-zero grant is always an accepted handshake; hand priority to
    // the other port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (grant != 2'b00) begin
            ptr <= grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Arbitrates word-level commands from two requesters (port 0
//               control unit, port 1 debug loader) and expands each into the
//               per-cycle FunSel/RegSel/ScrSel/I/OutASel pattern of the
//               8 x 32-bit register file. LOAD32 is built from one byte load
//               followed by three shift-left-8 cycles.
// Ports       : clk, rst (async, active-low)
//               cmd_valid/cmd_ready/cmd_op/cmd_idx/cmd_data : per-port command
//               rsp_valid/rsp_port/rsp_err/rsp_data         : completion
//               rf_FunSel/rf_RegSel/rf_ScrSel/rf_I/rf_OutASel/rf_OutBSel :
//                   registered register-file controls
//               rf_OutA : register-file read port A
// Options     : RFSEQ_STATS_EN adds stat_cnt0/stat_cnt1, saturating 16-bit
//               per-port completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int ARB_RR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd_valid,
    output logic [1:0]       cmd_ready,
    input  logic [1:0][2:0]  cmd_op,
    input  logic [1:0][2:0]  cmd_idx,
    input  logic [1:0][31:0] cmd_data,
    output logic             rsp_valid,
    output logic             rsp_port,
    output logic             rsp_err,
    output logic [31:0]      rsp_data,
    output logic [2:0]       rf_FunSel,
    output logic [3:0]       rf_RegSel,
    output logic [3:0]       rf_ScrSel,
    output logic [7:0]       rf_I,
    output logic [2:0]       rf_OutASel,
    output logic [2:0]       rf_OutBSel,
    input  logic [31:0]      rf_OutA
`ifdef RFSEQ_STATS_EN
    ,
    output logic [15:0]      stat_cnt0,
    output logic [15:0]      stat_cnt1
`endif
);

    state_t      state;
    logic        port_q;
    logic        is_load_q;
    logic [23:0] data_q;     // low three bytes still to be shifted in

    logic        accept;
    logic        acc_port;
    logic [2:0]  acc_op;
    logic [2:0]  acc_idx;
    logic [31:0] acc_data;
    logic [7:0]  acc_sel;
    logic [2:0]  acc_fs;

    rfseq_arbiter #(
        .ARB_RR (ARB_RR)
    ) u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .enable (state == ST_IDLE),
        .req    (cmd_valid),
        .grant  (cmd_ready)
    );

    always_comb begin
        accept   = |cmd_ready;
        acc_port = cmd_ready[1];
        acc_op   = cmd_op[acc_port];
        acc_idx  = cmd_idx[acc_port];
        acc_data = cmd_data[acc_port];
        acc_sel  = idx_to_sel(acc_idx);
        acc_fs   = FS_CLR;
        if (acc_op == OP_DEC) begin
            acc_fs = FS_DEC;
        end else if (acc_op == OP_INC) begin
            acc_fs = FS_INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            port_q     <= 1'b0;
            is_load_q  <= 1'b0;
            data_q     <= '0;
            rsp_valid  <= 1'b0;
            rsp_port   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_data   <= '0;
            rf_FunSel  <= '0;
            rf_RegSel  <= '0;
            rf_ScrSel  <= '0;
            rf_I       <= '0;
            rf_OutASel <= '0;
            rf_OutBSel <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        port_q     <= acc_port;
                        data_q     <= acc_data[23:0];
                        is_load_q  <= (acc_op == OP_LOAD32);
                        rf_OutBSel <= acc_idx;
                        case (acc_op)
                            OP_DEC, OP_INC, OP_CLR: begin
                                state     <= ST_WR1;
                                rf_FunSel <= acc_fs;
                                rf_RegSel <= acc_sel[3:0];
                                rf_ScrSel <= acc_sel[7:4];
                            end
                            OP_LOAD32: begin
                                state     <= ST_WR1;
                                rf_FunSel <= FS_LOAD;
                                rf_I      <= acc_data[31:24];
                                rf_RegSel <= acc_sel[3:0];
                                rf_ScrSel <= acc_sel[7:4];
                            end
                            OP_READ: begin
                                state      <= ST_RD;
                                rf_OutASel <= acc_idx;
                            end
                            default: begin
                                // Illegal opcode: respond immediately, no write
                                state     <= ST_RSP;
                                rsp_valid <= 1'b1;
                                rsp_port  <= acc_port;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                ST_WR1, ST_LB2, ST_LB1: begin
                    if (state == ST_WR1 && !is_load_q) begin
                        state     <= ST_RSP;
                        rf_FunSel <= '0;
                        rf_RegSel <= '0;
                        rf_ScrSel <= '0;
                        rsp_valid <= 1'b1;
                        rsp_port  <= port_q;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end else begin
                        // Target select is held; next byte shifts in
                        rf_FunSel <= FS_SHL8;
                        case (state)
                            ST_WR1: begin
                                state <= ST_LB2;
                                rf_I  <= data_q[23:16];
                            end
                            ST_LB2: begin
                                state <= ST_LB1;
                                rf_I  <= data_q[15:8];
                            end
                            default: begin
                                state <= ST_LB0;
                                rf_I  <= data_q[7:0];
                            end
                        endcase
                    end
                end
                ST_LB0: begin
                    state     <= ST_RSP;
                    rf_FunSel <= '0;
                    rf_RegSel <= '0;
                    rf_ScrSel <= '0;
                    rf_I      <= '0;
                    rsp_valid <= 1'b1;
                    rsp_port  <= port_q;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                end
                ST_RD: begin
                    state      <= ST_RSP;
                    rf_OutASel <= '0;
                    rsp_valid  <= 1'b1;
                    rsp_port   <= port_q;
                    rsp_err    <= 1'b0;
                    rsp_data   <= rf_OutA;
                end
                ST_RSP: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_port  <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RFSEQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else if (rsp_valid) begin
            if (!rsp_port && stat_cnt0 != 16'hFFFF) begin
                stat_cnt0 <= stat_cnt0 + 16'd1;
            end
            if (rsp_port && stat_cnt1 != 16'hFFFF) begin
                stat_cnt1 <= stat_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Directed self-checking bench for regfile_sequencer. A small
//               behavioural register file closes the loop on rf_OutA.
//               u_dut uses round-robin arbitration, u_dut_fp fixed priority.
//               RFSEQ_STATS_EN additionally checks the completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_sequencer;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       cmd_valid;
    logic [1:0]       cmd_ready;
    logic [1:0][2:0]  cmd_op;
    logic [1:0][2:0]  cmd_idx;
    logic [1:0][31:0] cmd_data;
    logic             rsp_valid, rsp_port, rsp_err;
    logic [31:0]      rsp_data;
    logic [2:0]       rf_FunSel, rf_OutASel, rf_OutBSel;
    logic [3:0]       rf_RegSel, rf_ScrSel;
    logic [7:0]       rf_I;
    logic [31:0]      rf_OutA;

    logic [1:0]       fp_cmd_valid;
    logic [1:0]       fp_cmd_ready;
    logic [1:0][2:0]  fp_cmd_op;
    logic [1:0][2:0]  fp_cmd_idx;
    logic [1:0][31:0] fp_cmd_data;
    logic             fp_rsp_valid, fp_rsp_port, fp_rsp_err;
    logic [31:0]      fp_rsp_data;
    logic [2:0]       fp_FunSel, fp_OutASel, fp_OutBSel;
    logic [3:0]       fp_RegSel, fp_ScrSel;
    logic [7:0]       fp_I;

`ifdef RFSEQ_STATS_EN
    logic [15:0] stat_cnt0, stat_cnt1, fp_stat_cnt0, fp_stat_cnt1;
`endif

    regfile_sequencer #(.ARB_RR(1)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .rf_FunSel(rf_FunSel), .rf_RegSel(rf_RegSel), .rf_ScrSel(rf_ScrSel), .rf_I(rf_I),
        .rf_OutASel(rf_OutASel), .rf_OutBSel(rf_OutBSel), .rf_OutA(rf_OutA)
`ifdef RFSEQ_STATS_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
    );

    regfile_sequencer #(.ARB_RR(0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .cmd_valid(fp_cmd_valid), .cmd_ready(fp_cmd_ready),
        .cmd_op(fp_cmd_op), .cmd_idx(fp_cmd_idx), .cmd_data(fp_cmd_data),
        .rsp_valid(fp_rsp_valid), .rsp_port(fp_rsp_port), .rsp_err(fp_rsp_err), .rsp_data(fp_rsp_data),
        .rf_FunSel(fp_FunSel), .rf_RegSel(fp_RegSel), .rf_ScrSel(fp_ScrSel), .rf_I(fp_I),
        .rf_OutASel(fp_OutASel), .rf_OutBSel(fp_OutBSel), .rf_OutA(32'h0)
`ifdef RFSEQ_STATS_EN
        , .stat_cnt0(fp_stat_cnt0), .stat_cnt1(fp_stat_cnt1)
`endif
    );

    // ---------------- behavioural register file ----------------
    logic [31:0] rf_model [8];
    logic        model_clear;
    logic [7:0]  wen;

    function automatic logic [31:0] rf_next(input logic [2:0] fs, input logic [31:0] v,
                                            input logic [7:0] b);
        case (fs)
            3'b000:  rf_next = v - 32'd1;
            3'b001:  rf_next = v + 32'd1;
            3'b010:  rf_next = {24'h0, b};
            3'b011:  rf_next = 32'h0;
            3'b110:  rf_next = {v[23:0], b};
            default: rf_next = v;
        endcase
    endfunction

    assign wen     = {rf_ScrSel, rf_RegSel};
    assign rf_OutA = rf_model[rf_OutASel];

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (model_clear) begin
                rf_model[i] <= 32'h0;
            end else if (wen[i]) begin
                rf_model[i] <= rf_next(rf_FunSel, rf_model[i], rf_I);
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output logic [1:0] grant);
        int w = 0;
        #1;
        while (cmd_ready == 2'b00 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        grant = cmd_ready;
        check("ready_seen", 32'(grant != 2'b00), 32'd1);
    endtask

    task automatic fp_wait_ready(output logic [1:0] grant);
        int w = 0;
        #1;
        while (fp_cmd_ready == 2'b00 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        grant = fp_cmd_ready;
        check("fp_ready_seen", 32'(grant != 2'b00), 32'd1);
    endtask

    // Consume the accept edge, drop the listed valids, then count edges
    // until rsp_valid is seen (1 = first cycle after accept).
    task automatic accept_and_wait(input logic [1:0] drop, output int lat);
        @(posedge clk);
        #1;
        cmd_valid = cmd_valid & ~drop;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_cmd(input string tag, input int port, input logic [2:0] op,
                          input logic [2:0] idx, input logic [31:0] data,
                          input int exp_lat, output logic [31:0] rdata);
        logic [1:0] g;
        int lat;
        @(negedge clk);
        cmd_valid[port] = 1'b1;
        cmd_op[port]    = op;
        cmd_idx[port]   = idx;
        cmd_data[port]  = data;
        wait_ready(g);
        check({tag, "_grant"}, 32'(g), (port == 1) ? 32'd2 : 32'd1);
        accept_and_wait((port == 1) ? 2'b10 : 2'b01, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_port"}, 32'(rsp_port), 32'(port));
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        rdata = rsp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g;
        logic [31:0] rd;
        int          lat;
        logic [7:0]  ld_bytes [4];
        logic [2:0]  ld_fs    [4];

        ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        ld_fs    = '{FS_LOAD, FS_SHL8, FS_SHL8, FS_SHL8};

        rst          = 1'b1;
        cmd_valid    = '0;
        cmd_op       = '0;
        cmd_idx      = '0;
        cmd_data     = '0;
        fp_cmd_valid = '0;
        fp_cmd_op    = '0;
        fp_cmd_idx   = '0;
        fp_cmd_data  = '0;
        model_clear  = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("rst_funsel", 32'(rf_FunSel), 32'd0);
        check("rst_regsel", 32'(rf_RegSel), 32'd0);
        check("rst_scrsel", 32'(rf_ScrSel), 32'd0);
        check("rst_i", 32'(rf_I), 32'd0);
        check("rst_outa", 32'(rf_OutASel), 32'd0);
        check("rst_outb", 32'(rf_OutBSel), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        model_clear = 1'b0;

        // ---- LOAD32 R3 = 0xDEADBEEF, cycle-by-cycle pattern ----
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_LOAD32;
        cmd_idx[0]   = 3'd2;
        cmd_data[0]  = 32'hDEADBEEF;
        wait_ready(g);
        check("ld_grant", 32'(g), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        check("ld_outb", 32'(rf_OutBSel), 32'd2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ld_fs%0d", k), 32'(rf_FunSel), 32'(ld_fs[k]));
            check($sformatf("ld_i%0d", k), 32'(rf_I), 32'(ld_bytes[k]));
            check($sformatf("ld_regsel%0d", k), 32'(rf_RegSel), 32'h4);
            check($sformatf("ld_scrsel%0d", k), 32'(rf_ScrSel), 32'h0);
            check($sformatf("ld_norsp%0d", k), 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("ld_rsp_t5", 32'(rsp_valid), 32'd1);
        check("ld_rsp_port", 32'(rsp_port), 32'd0);
        check("ld_rsp_err", 32'(rsp_err), 32'd0);
        check("ld_rsp_data", rsp_data, 32'd0);
        check("ld_we_off", 32'({rf_RegSel, rf_ScrSel}), 32'd0);

        do_cmd("rd_r3", 0, OP_READ, 3'd2, 32'h0, 2, rd);
        check("rd_r3_data", rd, 32'hDEADBEEF);

        // ---- illegal opcode on port 1 ----
        @(negedge clk);
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 3'b110;
        cmd_idx[1]   = 3'd3;
        wait_ready(g);
        check("ill_grant", 32'(g), 32'd2);
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        check("ill_rsp_t1", 32'(rsp_valid), 32'd1);
        check("ill_err", 32'(rsp_err), 32'd1);
        check("ill_port", 32'(rsp_port), 32'd1);
        check("ill_data", rsp_data, 32'd0);
        check("ill_no_we", 32'({rf_RegSel, rf_ScrSel}), 32'd0);

        // ---- round-robin: both ports INC S2 ----
        @(negedge clk);
        cmd_valid = 2'b11;
        cmd_op    = {OP_INC, OP_INC};
        cmd_idx   = {3'd5, 3'd5};
        for (int k = 0; k < 4; k++) begin
            wait_ready(g);
            check($sformatf("rr_grant%0d", k), 32'(g), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            if (k == 3) cmd_valid = 2'b00;
            check($sformatf("rr_fs%0d", k), 32'(rf_FunSel), 32'(FS_INC));
            check($sformatf("rr_scrsel%0d", k), 32'(rf_ScrSel), 32'h2);
            check($sformatf("rr_regsel%0d", k), 32'(rf_RegSel), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'd1);
            check($sformatf("rr_port%0d", k), 32'(rsp_port), (k % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        do_cmd("rd_s2", 0, OP_READ, 3'd5, 32'h0, 2, rd);
        check("rd_s2_data", rd, 32'd4);
        do_cmd("dec_s2", 1, OP_DEC, 3'd5, 32'h0, 2, rd);
        do_cmd("rd_s2b", 1, OP_READ, 3'd5, 32'h0, 2, rd);
        check("rd_s2b_data", rd, 32'd3);

        // ---- fixed priority: port 0 starves port 1 ----
        @(negedge clk);
        fp_cmd_valid = 2'b11;
        fp_cmd_op    = {OP_INC, OP_INC};
        fp_cmd_idx   = {3'd0, 3'd0};
        for (int k = 0; k < 3; k++) begin
            fp_wait_ready(g);
            check($sformatf("fp_grant%0d", k), 32'(g), 32'd1);
            @(posedge clk);
            #1;
            lat = 1;
            while (!fp_rsp_valid && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("fp_lat%0d", k), 32'(lat), 32'd2);
            check($sformatf("fp_port%0d", k), 32'(fp_rsp_port), 32'd0);
        end
        fp_cmd_valid[0] = 1'b0;
        fp_wait_ready(g);
        check("fp_grant_p1", 32'(g), 32'd2);
        @(posedge clk);
        #1;
        fp_cmd_valid = 2'b00;
        lat = 1;
        while (!fp_rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("fp_lat_p1", 32'(lat), 32'd2);
        check("fp_port_p1", 32'(fp_rsp_port), 32'd1);

        // ---- asynchronous reset during LB1 of a LOAD32 ----
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_LOAD32;
        cmd_idx[0]   = 3'd6;
        cmd_data[0]  = 32'h11223344;
        wait_ready(g);
        @(posedge clk);
        #1;
        cmd_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("lb1_fs", 32'(rf_FunSel), 32'(FS_SHL8));
        check("lb1_i", 32'(rf_I), 32'h33);
        check("lb1_scrsel", 32'(rf_ScrSel), 32'h4);
        #2;
        rst = 1'b0;
        #1;
        check("arst_fs", 32'(rf_FunSel), 32'd0);
        check("arst_scrsel", 32'(rf_ScrSel), 32'd0);
        check("arst_i", 32'(rf_I), 32'd0);
        check("arst_outb", 32'(rf_OutBSel), 32'd0);
        check("arst_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst          = 1'b1;
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_CLR;
        cmd_idx[0]   = 3'd6;
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        accept_and_wait(2'b01, lat);
        check("clr_lat", 32'(lat), 32'd2);
        check("clr_port", 32'(rsp_port), 32'd0);
        do_cmd("rd_s3", 0, OP_READ, 3'd6, 32'h0, 2, rd);
        check("rd_s3_data", rd, 32'd0);
        do_cmd("inc_s3", 0, OP_INC, 3'd6, 32'h0, 2, rd);
        do_cmd("rd_s3b", 1, OP_READ, 3'd6, 32'h0, 2, rd);
        check("rd_s3b_data", rd, 32'd1);
        @(negedge clk);
        @(negedge clk);
`ifdef RFSEQ_STATS_EN
        check("stat_cnt0", 32'(stat_cnt0), 32'd3);
        check("stat_cnt1", 32'(stat_cnt1), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Sequencer and arbiter in front of the 8-entry x 32-bit register file (R1-R4, S1-S4; 8-bit load port I, 3-bit FunSel, one-hot RegSel/ScrSel, OutASel/OutBSel).
- Accepts word-level commands from two requesters: port 0 is the control unit, port 1 is the debug loader.
- Arbitrates between them and expands each command into the per-cycle FunSel/RegSel/ScrSel/I/OutASel pattern.
- Builds a 32-bit load from four byte cycles: load, then three shift-left-8 cycles.
- Returns completion and read data to the requester.

Parameters:
- ARB_RR, default 1: 1 = round-robin; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  2  per-port command valid
- cmd_ready  out  2  per-port accept; at most one bit set
- cmd_op  in  2x3  per-port opcode: 000 DEC, 001 INC, 010 CLR, 011 LOAD32, 100 READ, 101-111 illegal
- cmd_idx  in  2x3  per-port target: 0-3 = R1-R4, 4-7 = S1-S4
- cmd_data  in  2x32  per-port LOAD32 operand
- rsp_valid  out  1  one-cycle completion pulse
- rsp_port  out  1  port that owned the completed command
- rsp_err  out  1  illegal opcode flag
- rsp_data  out  32  READ result; 0 for other ops
- rf_FunSel  out  3  to register file
- rf_RegSel  out  4  to register file
- rf_ScrSel  out  4  to register file
- rf_I  out  8  to register file
- rf_OutASel  out  3  to register file
- rf_OutBSel  out  3  to register file; held at cmd_idx of current command
- rf_OutA  in  32  from register file

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - rf_RegSel, rf_ScrSel, rf_FunSel, rf_I, rf_OutASel and rf_OutBSel all read 0.
  - rsp_valid, rsp_port, rsp_err and rsp_data are 0.
  - Round-robin pointer points to port 0.
  - Register file contents are not touched. A LOAD32 aborted mid-sequence leaves a partial value in the target.
- All rf_* outputs are registered. Write enables are 0 in every cycle not listed below, and exactly one RegSel/ScrSel bit is set during a write cycle.
- Arbitration:
  - cmd_ready is combinational and is high only in IDLE, for the granted port with cmd_valid set.
  - Handshake completes when cmd_valid & cmd_ready.
  - When both ports are valid with ARB_RR=1, the grant goes to the port not granted last; the pointer updates on each accept.
  - With ARB_RR=0, port 0 always wins.
  - A requester must hold op/idx/data stable until it sees ready. Dropping valid before ready is legal, and the request is then lost.
- States: IDLE, WR1, LB2, LB1, LB0, RD, RSP.
  - Accept in cycle T: command is latched, including the port number.
  - DEC/INC/CLR go to WR1. Cycle T+1 drives the write: FunSel 000/001/011 (CLR uses FunSel 011, clear). Then RSP.
  - LOAD32 goes to WR1 with FunSel 010 and I = data[31:24]. It then steps through LB2, LB1, LB0 with FunSel 110 and I = data[23:16], data[15:8], data[7:0]. Then RSP.
  - READ goes to RD. RD drives rf_OutASel = idx with no write enables. At the end of RD, rf_OutA is captured into rsp_data. Then RSP.
  - Illegal opcode goes straight to RSP with rsp_err=1 and no write.
  - RSP asserts rsp_valid for one cycle, then returns to IDLE. No accept takes place during RSP.
- Latency from accept cycle T to rsp_valid:
  - INC/DEC/CLR: T+2.
  - LOAD32: T+5.
  - READ: T+2.
  - Illegal: T+1.
- Register file value after LOAD32 equals cmd_data exactly: byte 3 is zero-extended, then three 8-bit left shifts.
- idx 0-3 drives RegSel bit idx. idx 4-7 drives ScrSel bit idx-4.
- Back-to-back throughput: one new command per (latency+1) cycles. There is no pipelining.

Optional Feature:
- Macro: RFSEQ_STATS_EN.
- When defined, adds outputs stat_cnt0 and stat_cnt1, 16 bits each. Each counts rsp_valid pulses for its port, saturates at 0xFFFF, and is cleared by rst.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package regfile_pkg holds:
  - opcode constants OP_DEC/OP_INC/OP_CLR/OP_LOAD32/OP_READ;
  - FunSel constants FS_DEC=000, FS_INC=001, FS_LOAD=010, FS_CLR=011, FS_SHL8=110;
  - state enum typedef;
  - index-to-select function.
- One sub-module: rfseq_arbiter, a 2-port round-robin/fixed grant with pointer.

Test Plan:
- Reset, then port 0 LOAD32 idx=2 data=0xDEADBEEF:
  - FunSel sequence 010,110,110,110;
  - I = DE,AD,BE,EF;
  - RegSel=0100 for 4 cycles;
  - rsp_valid at T+5.
  - Then READ idx=2 returns rsp_data=0xDEADBEEF.
- Both ports valid together for 4 commands (INC idx=5), ARB_RR=1:
  - grants alternate 0,1,0,1;
  - ScrSel=0010 during each write;
  - S2 ends at 4.
- Same stimulus with ARB_RR=0: port 0 receives all grants while valid; port 1 is starved until port 0 drops valid.
- Illegal opcode 110 on port 1: no write enables; rsp_valid at T+1 with rsp_err=1, rsp_port=1.
- Assert rst low during LB1 of a LOAD32:
  - outputs go 0 immediately (asynchronous);
  - after release, state is IDLE and cmd_ready=01 when port 0 is valid.
- With RFSEQ_STATS_EN defined: 3 completions on port 0 and 1 on port 1 give stat_cnt0=3 and stat_cnt1=1.
